ws281x_split_ctrl: RTL
======================

// Module: ws281x_split_ctrl
// PURPOSE
//  Sequences a pulse-width timer to decode an incoming WS281X serial stream and routes it to NUM_PORTS outputs.
//  Bits are classified by high-time and counted per pixel group. The first PIXELS_PER_PORT pixels go to port 0,
//  the next group to port 1, and so on. Any remainder goes to the last port.
//  A latch gap (long low) ends the frame and re-arms routing at port 0.
//  Sits between the board input pin and the per-strip output drivers.
// PARAMETERS
//  NUM_PORTS        4     output ports (2..8)
//  PIXELS_PER_PORT  16    pixels routed to each port before advancing
//  BITS_PER_PIXEL   24    bits per pixel (24 RGB, 32 RGBW)
//  T_THRESH         12    high-time cycles; >= is a '1', < is a '0' (0.6us at 20MHz)
//  T_MAX_HIGH       40    high-time cycles above which the pulse is an error
//  T_LATCH          1000  low-time cycles that mark frame end (50us at 20MHz)
//  TIMER_W          10    timer width; 2**TIMER_W-1 >= T_LATCH
// PORTS
//  Clock      in   1          system clock, all logic on posedge
//  Reset_n    in   1          asynchronous reset, active-low
//  DIn        in   1          raw WS281X data, asynchronous to Clock
//  DOut       out  NUM_PORTS  routed data; exactly 0 or 1 bit may be high
//  Bit_valid  out  1          1-cycle pulse when a bit is decoded
//  Bit_data   out  1          decoded bit value, valid with Bit_valid
//  Port_sel   out  3          index of the port currently receiving data
//  Frame_done out  1          1-cycle pulse at latch detect, if the frame held >=1 bit
//  Error      out  1          sticky high-time violation; cleared at next latch
// BEHAVIOUR
//  Reset (Reset_n=0, async): all outputs 0, state=SYNC, timer=0, bit_cnt=0, Port_sel=0, sync flops=0.
//  Input: DIn passes through a 2-flop synchronizer to give din_s; edges come from din_s vs a delayed copy.
//  Timer: cleared on every din_s edge, otherwise +1; saturates at all-ones and never wraps.
//  FSM:
//   SYNC: ignore data; all DOut=0.
//     Timer >= T_LATCH with din_s=0 -> IDLE, no Frame_done.
//     Any rising edge restarts the wait.
//   IDLE: rising edge -> HIGH.
//   HIGH: on falling edge, Bit_data = (timer >= T_THRESH), pulse Bit_valid, bit_cnt+1, -> LOW.
//     Timer > T_MAX_HIGH while high -> set Error, force DOut=0, -> SYNC.
//   LOW: rising edge -> HIGH.
//     Timer == T_LATCH -> pulse Frame_done if bit_cnt != 0; bit_cnt=0, Port_sel=0, -> IDLE.
//  Routing: DOut registered each cycle as DOut[Port_sel] <= din_s while in IDLE/HIGH/LOW; all other bits are 0.
//   DIn->DOut latency is 3 clocks; pulse width is preserved within +/-1 clock.
//  Port advance: at the falling edge that makes bit_cnt == PIXELS_PER_PORT*BITS_PER_PIXEL:
//   Port_sel+1 and bit_cnt=0, unless Port_sel == NUM_PORTS-1, where Port_sel holds and bit_cnt saturates.
//   Switching only on a falling edge guarantees no runt pulse on either port.
//  Simultaneous events:
//   Latch and advance cannot coincide, since latch occurs only in LOW.
//   Error is set in the same cycle as the SYNC entry.
//  Reset mid-frame: outputs drop to 0 immediately (async); after release a full latch gap is required before routing.
//  Widths: bit_cnt is $clog2(PIXELS_PER_PORT*BITS_PER_PIXEL+1) bits; Port_sel is zero-extended to 3 bits.
// STRUCTURE
//  ws281x_defs.vh: FSM state localparams (SYNC, IDLE, HIGH, LOW) and default timing constants.
//  Sub-module pulse_timer (Clock, Reset_n, Clear, Count[TIMER_W]):
//   saturating up-counter with synchronous clear; instantiated once.
//  Everything else (synchronizer, edge detect, FSM, bit counter, routing mux) stays in this module.
// TESTING (20MHz clock, defaults, pulse lengths in cycles)
//  1. Reset, hold DIn=0 for 1000 -> IDLE, DOut=0, no Frame_done, Port_sel=0.
//  2. One pixel of bits high 8/low 17 then high 16/low 9, alternating ->
//     24 Bit_valid pulses with Bit_data 0,1,0,1...; waveform on DOut[0] delayed by 3 clocks.
//  3. 17 pixels, then low 1000 -> 384 bits on DOut[0], pixel 17 on DOut[1], Port_sel=1, then Frame_done pulse, Port_sel=0.
//  4. 70 pixels -> ports 0-2 get 16 pixels each, port 3 gets 22 pixels, Port_sel stays 3.
//  5. High pulse of 50 -> Error=1 at cycle 41 of the pulse, DOut all 0, following bits ignored until a 1000-cycle low;
//     Error then clears.
//  6. Assert Reset_n=0 mid-pixel -> DOut=0 in the same cycle; after release, data is ignored until a latch gap.

Source files
------------

// File: rtl/ws281x_split_ctrl_pkg.sv
// Shared types and default timing for the WS281X split controller.
package ws281x_split_ctrl_pkg;

  typedef enum logic [1:0] {
    StSync,
    StIdle,
    StHigh,
    StLow
  } state_e;

  localparam int unsigned DefNumPorts      = 4;
  localparam int unsigned DefPixelsPerPort = 16;
  localparam int unsigned DefBitsPerPixel  = 24;
  localparam int unsigned DefTThresh       = 12;
  localparam int unsigned DefTMaxHigh      = 40;
  localparam int unsigned DefTLatch        = 1000;
  localparam int unsigned DefTimerW        = 10;
  localparam int unsigned PortSelW         = 3;

endpackage

// File: rtl/ws281x_split_ctrl_if.sv
// Serial input plus routed outputs and decode status of the split controller.
interface ws281x_split_ctrl_if
  import ws281x_split_ctrl_pkg::*;
#(
  parameter int unsigned NumPorts = DefNumPorts
);
  logic                din;
  logic [NumPorts-1:0] dout;
  logic                bit_valid;
  logic                bit_data;
  logic [PortSelW-1:0] port_sel;
  logic                frame_done;
  logic                error;

  modport master (
    output din,
    input  dout, bit_valid, bit_data, port_sel, frame_done, error
  );

  modport slave (
    input  din,
    output dout, bit_valid, bit_data, port_sel, frame_done, error
  );
endinterface

// File: rtl/ws281x_split_ctrl_pulse_timer.sv
// Saturating up-counter with synchronous clear; measures high/low times.
module ws281x_split_ctrl_pulse_timer #(
  parameter int unsigned TimerW = 10
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  output logic [TimerW-1:0] o_count
);
  logic [TimerW-1:0] r_count;

  // Count up, clear on request, stick at all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (r_count != '1) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
endmodule

// File: rtl/ws281x_split_ctrl.sv
// Decodes a WS281X stream by pulse width and routes it to NumPorts strips.
module ws281x_split_ctrl
  import ws281x_split_ctrl_pkg::*;
#(
  parameter int unsigned NumPorts      = DefNumPorts,
  parameter int unsigned PixelsPerPort = DefPixelsPerPort,
  parameter int unsigned BitsPerPixel  = DefBitsPerPixel,
  parameter int unsigned TThresh       = DefTThresh,
  parameter int unsigned TMaxHigh      = DefTMaxHigh,
  parameter int unsigned TLatch        = DefTLatch,
  parameter int unsigned TimerW        = DefTimerW
) (
  input logic                i_clk,
  input logic                i_rst_n,
  ws281x_split_ctrl_if.slave bus
);
  localparam int unsigned BitsPerPort = PixelsPerPort * BitsPerPixel;
  localparam int unsigned CntW        = $clog2(BitsPerPort + 1);

  localparam logic [CntW-1:0]     CntMax    = CntW'(BitsPerPort);
  localparam logic [CntW-1:0]     CntLast   = CntW'(BitsPerPort - 1);
  localparam logic [PortSelW-1:0] LastPort  = PortSelW'(NumPorts - 1);
  localparam logic [TimerW-1:0]   TThreshC  = TimerW'(TThresh);
  localparam logic [TimerW-1:0]   TMaxHighC = TimerW'(TMaxHigh);
  localparam logic [TimerW-1:0]   TLatchC   = TimerW'(TLatch);

  logic                r_sync1, r_sync2, r_din_d;
  logic                w_rise, w_fall, w_edge;
  logic [TimerW-1:0]   w_count;

  state_e              r_state, w_state_d;
  logic [CntW-1:0]     r_bit_cnt, w_bit_cnt_d;
  logic [PortSelW-1:0] r_port_sel, w_port_sel_d;
  logic                r_frame_any, w_frame_any_d;
  logic [NumPorts-1:0] r_dout, w_dout_d;
  logic                r_bit_valid, w_bit_valid_d;
  logic                r_bit_data, w_bit_data_d;
  logic                r_frame_done, w_frame_done_d;
  logic                r_error, w_error_d;
  logic                w_route;

  // Two-flop synchronizer plus a delayed copy for edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_din_d <= 1'b0;
    end else begin
      r_sync1 <= bus.din;
      r_sync2 <= r_sync1;
      r_din_d <= r_sync2;
    end
  end

  assign w_rise = r_sync2 & ~r_din_d;
  assign w_fall = ~r_sync2 & r_din_d;
  assign w_edge = w_rise | w_fall;

  ws281x_split_ctrl_pulse_timer #(
    .TimerW (TimerW)
  ) u_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (w_edge),
    .o_count (w_count)
  );

  // Next-state, bit counting, port advance and routed output.
  always_comb begin
    w_state_d      = r_state;
    w_bit_cnt_d    = r_bit_cnt;
    w_port_sel_d   = r_port_sel;
    w_frame_any_d  = r_frame_any;
    w_bit_valid_d  = 1'b0;
    w_bit_data_d   = 1'b0;
    w_frame_done_d = 1'b0;
    w_error_d      = r_error;
    w_route        = (r_state != StSync);

    unique case (r_state)
      StSync: begin
        if (!r_sync2 && (w_count >= TLatchC)) begin
          w_state_d     = StIdle;
          w_error_d     = 1'b0;
          w_bit_cnt_d   = '0;
          w_port_sel_d  = '0;
          w_frame_any_d = 1'b0;
        end
      end
      StIdle: begin
        if (w_rise) w_state_d = StHigh;
      end
      StHigh: begin
        if (w_fall) begin
          w_bit_valid_d = 1'b1;
          w_bit_data_d  = (w_count >= TThreshC);
          w_frame_any_d = 1'b1;
          w_state_d     = StLow;
          // Port only changes here, while the line is low, so no runt pulses.
          if (r_bit_cnt == CntMax) begin
            w_bit_cnt_d = r_bit_cnt;
          end else if ((r_bit_cnt == CntLast) && (r_port_sel != LastPort)) begin
            w_port_sel_d = r_port_sel + 1'b1;
            w_bit_cnt_d  = '0;
          end else begin
            w_bit_cnt_d = r_bit_cnt + 1'b1;
          end
        end else if (w_count > TMaxHighC) begin
          w_error_d = 1'b1;
          w_route   = 1'b0;
          w_state_d = StSync;
        end
      end
      StLow: begin
        if (w_rise) begin
          w_state_d = StHigh;
        end else if (w_count == TLatchC) begin
          w_frame_done_d = r_frame_any;
          w_bit_cnt_d    = '0;
          w_port_sel_d   = '0;
          w_frame_any_d  = 1'b0;
          w_state_d      = StIdle;
        end
      end
      default: w_state_d = StSync;
    endcase

    for (int unsigned p = 0; p < NumPorts; p++) begin
      w_dout_d[p] = w_route && (r_port_sel == PortSelW'(p)) && r_sync2;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StSync;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Counters, routing and registered status outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bit_cnt    <= '0;
      r_port_sel   <= '0;
      r_frame_any  <= 1'b0;
      r_dout       <= '0;
      r_bit_valid  <= 1'b0;
      r_bit_data   <= 1'b0;
      r_frame_done <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_bit_cnt    <= w_bit_cnt_d;
      r_port_sel   <= w_port_sel_d;
      r_frame_any  <= w_frame_any_d;
      r_dout       <= w_dout_d;
      r_bit_valid  <= w_bit_valid_d;
      r_bit_data   <= w_bit_data_d;
      r_frame_done <= w_frame_done_d;
      r_error      <= w_error_d;
    end
  end

  assign bus.dout       = r_dout;
  assign bus.bit_valid  = r_bit_valid;
  assign bus.bit_data   = r_bit_data;
  assign bus.port_sel   = r_port_sel;
  assign bus.frame_done = r_frame_done;
  assign bus.error      = r_error;
endmodule
